tf_round_sched: RTL and testbench



---
 rtl/tf_pkg.sv | 52 +++++
 rtl/tf_mix.sv | 28 ++
 rtl/tf_permute.sv | 21 ++
 rtl/tf_round_sched.sv | 174 +++++++++++++++++
 tb/tb_tf_round_sched.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tf_pkg
//  Description : Shared types and constants for the Threefish-1024 round
//                sequencer: word type, key-schedule constant, rotation and
//                permutation tables, sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tf_pkg;

    localparam int NW = 16;

    typedef logic [63:0] word_t;

    // Key-schedule parity constant folded into the extended key word k16
    localparam word_t C240 = 64'h1BD11BDAA9FC1A22;

    // Threefish-1024 rotation amounts, indexed by {round mod 8, pair index}
    localparam logic [5:0] C_ROT [64] = '{
        6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37,
        6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52,
        6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17,
        6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25,
        6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30,
        6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41,
        6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25,
        6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20
    };

    // Word permutation: output word i takes input word C_PERM[i]
    localparam int C_PERM [NW] = '{0, 9, 2, 13, 6, 11, 4, 15,
                                   10, 7, 12, 3, 14, 5, 8, 1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tf_state_t;

    // Word-wise modular addition of two 16-word blocks (no carry between words)
    function automatic logic [NW*64-1:0] add_words(input logic [NW*64-1:0] a,
                                                   input logic [NW*64-1:0] b);
        logic [NW*64-1:0] sum;
        sum = '0;
        for (int i = 0; i < NW; i++) begin
            sum[i*64 +: 64] = a[i*64 +: 64] + b[i*64 +: 64];
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tf_mix.sv
`default_nettype none
// ============================================================================
//  Module      : tf_mix
//  Description : One Threefish MIX: y0 = x0 + x1, y1 = rotl(x1, rot) ^ y0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tf_mix
    import tf_pkg::*;
(
    input  word_t      x0,
    input  word_t      x1,
    input  logic [5:0] rot,
    output word_t      y0,
    output word_t      y1
);

    word_t w_sum;
    word_t w_rot;

    assign w_sum = x0 + x1;
    // Rotation amounts are never zero, so the 64-bit right shift never occurs
    assign w_rot = (x1 << rot) | (x1 >> (7'd64 - {1'b0, rot}));

    assign y0 = w_sum;
    assign y1 = w_rot ^ w_sum;

endmodule
`default_nettype wire

// File: rtl/tf_permute.sv
`default_nettype none
// ============================================================================
//  Module      : tf_permute
//  Description : Threefish-1024 word permutation (pure wiring).
//  Revision    : 1.0 - initial release
// ============================================================================
module tf_permute
    import tf_pkg::*;
(
    input  logic [NW*64-1:0] x,
    output logic [NW*64-1:0] y
);

    generate
        for (genvar i = 0; i < NW; i++) begin : g_word
            assign y[i*64 +: 64] = x[C_PERM[i]*64 +: 64];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tf_round_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tf_round_sched
//  Description : Threefish-1024 round sequencer. Latches key/tweak/plaintext,
//                runs NR rounds of MIX + permute with on-the-fly subkey
//                injection, and holds the ciphertext on a valid/ready port.
//                Optional macro TF_ROUND_UNROLL2_EN: two rounds per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tf_round_sched
    import tf_pkg::*;
#(
    parameter int NR = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NW*64-1:0]  key,
    input  logic [127:0]      tweak,
    input  logic [NW*64-1:0]  pt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NW*64-1:0]  ct,
    output logic              busy
);

`ifdef TF_ROUND_UNROLL2_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam int RW = $clog2(NR + 1);
    localparam int BW = NW * 64;
    localparam int KW = (NW + 1) * 64;

    tf_state_t        r_state;
    logic [RW-1:0]    r_round;
    logic [BW-1:0]    r_x;
    logic [KW-1:0]    r_key;
    logic [191:0]     r_tw;

    word_t            w_kx;
    logic [KW-1:0]    w_k_in;
    logic [191:0]     w_t_in;
    logic [BW-1:0]    w_load;
    logic [BW-1:0]    w_rounds;
    logic [BW-1:0]    w_sk_run;
    logic [BW-1:0]    w_next;
    logic [RW-1:0]    w_r_last;
    logic [RW-1:0]    w_r_next;
    logic             w_inject;
    logic             w_last;

    // Subkey s: word i is k[(s+i) mod 17], with tweak words on 13/14 and s on 15
    function automatic logic [BW-1:0] subkey(input logic [RW-1:0] sk_s,
                                             input logic [KW-1:0] sk_k,
                                             input logic [191:0]  sk_t);
        logic [BW-1:0] sk;
        word_t         w;
        int unsigned   si;
        sk = '0;
        si = {{(32-RW){1'b0}}, sk_s};
        for (int i = 0; i < NW; i++) begin
            w = sk_k[((si + i) % 17) * 64 +: 64];
            if (i == 13) w = w + sk_t[(si % 3) * 64 +: 64];
            if (i == 14) w = w + sk_t[((si + 1) % 3) * 64 +: 64];
            if (i == 15) w = w + 64'(si);
            sk[i*64 +: 64] = w;
        end
        return sk;
    endfunction

    // Extended key word k16 from the incoming key
    always_comb begin
        w_kx = C240;
        for (int i = 0; i < NW; i++) begin
            w_kx = w_kx ^ key[i*64 +: 64];
        end
    end

    assign w_k_in = {w_kx, key};
    assign w_t_in = {tweak[63:0] ^ tweak[127:64], tweak};
    assign w_load = add_words(pt, subkey('0, w_k_in, w_t_in));

    // Round datapath: STAGES chained rounds of 8 MIX + permute
    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            logic [BW-1:0] w_in;
            logic [BW-1:0] w_mix;
            logic [BW-1:0] w_out;
            logic [2:0]    w_d;

            if (s == 0) begin : g_first
                assign w_in = r_x;
            end else begin : g_chain
                assign w_in = g_stage[s-1].w_out;
            end

            assign w_d = r_round[2:0] + 3'(s);

            for (genvar j = 0; j < NW/2; j++) begin : g_mix
                tf_mix u_mix (
                    .x0  (w_in[(2*j)*64 +: 64]),
                    .x1  (w_in[(2*j+1)*64 +: 64]),
                    .rot (C_ROT[{w_d, 3'(j)}]),
                    .y0  (w_mix[(2*j)*64 +: 64]),
                    .y1  (w_mix[(2*j+1)*64 +: 64])
                );
            end

            tf_permute u_perm (
                .x (w_mix),
                .y (w_out)
            );
        end
    endgenerate

    assign w_rounds = g_stage[STAGES-1].w_out;

    // Subkey injection follows every fourth round; its index is (r+1)/4
    assign w_r_last = r_round + RW'(STAGES - 1);
    assign w_r_next = w_r_last + RW'(1);
    assign w_inject = (w_r_last[1:0] == 2'b11);
    assign w_last   = (w_r_last == RW'(NR - 1));
    assign w_sk_run = subkey(w_r_next >> 2, r_key, r_tw);
    assign w_next   = w_inject ? add_words(w_rounds, w_sk_run) : w_rounds;

    // Sequencer: accept a job, iterate the rounds, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_x     <= '0;
            r_key   <= '0;
            r_tw    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_key   <= w_k_in;
                        r_tw    <= w_t_in;
                        r_x     <= w_load;
                        r_round <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_x     <= w_next;
                    r_round <= r_round + RW'(STAGES);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_round <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign out_valid = (r_state == ST_DONE);
    assign ct        = r_x;

endmodule
`default_nettype wire

// File: tb/tb_tf_round_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tf_round_sched
//  Description : Self-checking bench for tf_round_sched with a word-array
//                Threefish-1024 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tf_round_sched;

    localparam int NR = 80;
`ifdef TF_ROUND_UNROLL2_EN
    localparam int LAT = NR / 2;
`else
    localparam int LAT = NR;
`endif
    localparam int TIMEOUT = 400;

    localparam int PI_TBL [16] = '{0, 9, 2, 13, 6, 11, 4, 15, 10, 7, 12, 3, 14, 5, 8, 1};
    localparam int ROT_TBL [8][8] = '{
        '{24, 13,  8, 47,  8, 17, 22, 37},
        '{38, 19, 10, 55, 49, 18, 23, 52},
        '{33,  4, 51, 13, 34, 41, 59, 17},
        '{ 5, 20, 48, 41, 47, 28, 16, 25},
        '{41,  9, 37, 31, 12, 47, 44, 30},
        '{16, 34, 56, 51,  4, 53, 42, 41},
        '{31, 44, 47, 46, 19, 42, 44, 25},
        '{ 9, 48, 35, 52, 23, 31, 37, 20}
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] key;
    logic [127:0]  tweak;
    logic [1023:0] pt;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] ct;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    tf_round_sched #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .tweak     (tweak),
        .pt        (pt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // Textbook Threefish-1024: subkey before every 4th round and after the last
    function automatic logic [1023:0] tf_ref(input logic [1023:0] k_in,
                                             input logic [127:0]  t_in,
                                             input logic [1023:0] p_in);
        logic [63:0]   k [17];
        logic [63:0]   t [3];
        logic [63:0]   v [16];
        logic [63:0]   f [16];
        logic [1023:0] res;
        k[16] = 64'h1BD11BDAA9FC1A22;
        for (int i = 0; i < 16; i++) begin
            k[i]  = k_in[i*64 +: 64];
            k[16] = k[16] ^ k[i];
            v[i]  = p_in[i*64 +: 64];
        end
        t[0] = t_in[63:0];
        t[1] = t_in[127:64];
        t[2] = t[0] ^ t[1];
        for (int d = 0; d <= NR; d++) begin
            if (d % 4 == 0) begin
                for (int i = 0; i < 16; i++) v[i] = v[i] + k[(d/4 + i) % 17];
                v[13] = v[13] + t[(d/4) % 3];
                v[14] = v[14] + t[(d/4 + 1) % 3];
                v[15] = v[15] + 64'(d/4);
            end
            if (d == NR) break;
            for (int j = 0; j < 8; j++) begin
                f[2*j]   = v[2*j] + v[2*j+1];
                f[2*j+1] = rotl(v[2*j+1], ROT_TBL[d % 8][j]) ^ f[2*j];
            end
            for (int i = 0; i < 16; i++) v[i] = f[PI_TBL[i]];
        end
        for (int i = 0; i < 16; i++) res[i*64 +: 64] = v[i];
        return res;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        key = '0; tweak = '0; pt = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic start_job(input logic [1023:0] k, input logic [127:0] t, input logic [1023:0] p);
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin tick(); n++; end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL start_wait: in_ready=%b required 1 within %0d cycles", in_ready, TIMEOUT);
        end
        key = k; tweak = t; pt = p; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Wait for the result, hold it for 'hold' cycles, then complete the handshake
    task automatic finish_job(input string name, input logic [1023:0] exp_ct, input int hold);
        int n = 0;
        int busy_bad = 0;
        int stable_bad = 0;
        logic [1023:0] first_ct;
        while (!out_valid && n < TIMEOUT) begin
            if (!busy) busy_bad++;
            tick(); n++;
        end
        checks++;
        if (cyc - acc_cyc != LAT) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc - acc_cyc, LAT);
        end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: low-while-running=%0d busy-at-done=%b required 0/0", name, busy_bad, busy);
        end
        checks++;
        if (ct !== exp_ct) begin
            failures++;
            $display("FAIL %s_ct: got %h required %h", name, ct, exp_ct);
        end
        first_ct = ct;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (ct !== first_ct || out_valid !== 1'b1 || in_ready !== 1'b0) stable_bad++;
        end
        checks++;
        if (stable_bad != 0) begin
            failures++;
            $display("FAIL %s_hold: unstable cycles=%0d required 0", name, stable_bad);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (ct !== '0) begin failures++; $display("FAIL reset_ct: got %h required 0", ct); end
    endtask

    task automatic test_zero_vector();
        start_job('0, '0, '0);
        finish_job("zero", tf_ref('0, '0, '0), 0);
    endtask

    task automatic test_pattern_vector();
        logic [1023:0] k, p;
        logic [127:0]  t;
        for (int n = 0; n < 128; n++) begin
            k[8*n +: 8] = 8'(8'h10 + n);
            p[8*n +: 8] = 8'(8'hFF - n);
        end
        for (int n = 0; n < 16; n++) t[8*n +: 8] = 8'(n);
        start_job(k, t, p);
        finish_job("pattern", tf_ref(k, t, p), 0);
    endtask

    task automatic test_backpressure();
        logic [1023:0] k = rand1024(), p = rand1024();
        logic [127:0]  t = {$urandom, $urandom, $urandom, $urandom};
        start_job(k, t, p);
        finish_job("backpressure", tf_ref(k, t, p), 20);
    endtask

    task automatic test_ignore_in_valid();
        logic [1023:0] k = rand1024(), p = rand1024();
        logic [127:0]  t = {$urandom, $urandom, $urandom, $urandom};
        start_job(k, t, p);
        repeat (37 * LAT / NR) tick();
        pt = ~p; key = rand1024(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        finish_job("ignore", tf_ref(k, t, p), 2);
    endtask

    task automatic test_reset_mid();
        logic [1023:0] k = rand1024(), p = rand1024();
        logic [127:0]  t = {$urandom, $urandom, $urandom, $urandom};
        start_job(k, t, p);
        repeat (50 * LAT / NR) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ct !== '0) begin
            failures++;
            $display("FAIL midreset: in_ready=%b out_valid=%b busy=%b ct_zero=%b required 1/0/0/1",
                     in_ready, out_valid, busy, ct == '0);
        end
        k = rand1024(); p = rand1024();
        start_job(k, t, p);
        finish_job("after_reset", tf_ref(k, t, p), 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            logic [1023:0] k = rand1024(), p = rand1024();
            logic [127:0]  t = {$urandom, $urandom, $urandom, $urandom};
            start_job(k, t, p);
            finish_job("random", tf_ref(k, t, p), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        int            acc_q [$];
        logic [1023:0] exp_q [$];
        int            bad_ct = 0;
        int            bad_int = 0;
        int            n_out = 0;
        int            n = 0;
        logic          accepted = 1'b0;
        key = rand1024(); pt = rand1024(); tweak = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 3 * (LAT + 2) + 4; c++) begin
            if (accepted) begin key = rand1024(); pt = rand1024(); end
            accepted = 1'b0;
            if (in_ready) begin
                acc_q.push_back(cyc);
                exp_q.push_back(tf_ref(key, tweak, pt));
                accepted = 1'b1;
            end
            if (out_valid) begin
                n_out++;
                if (exp_q.size() == 0 || ct !== exp_q[0]) bad_ct++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            if (out_valid) begin
                n_out++;
                if (ct !== exp_q[0]) bad_ct++;
                void'(exp_q.pop_front());
            end
            tick(); n++;
        end
        out_ready = 1'b0;
        for (int i = 1; i < acc_q.size(); i++) begin
            if (acc_q[i] - acc_q[i-1] != LAT + 2) bad_int++;
        end
        checks++;
        if (acc_q.size() < 3 || bad_int != 0) begin
            failures++;
            $display("FAIL b2b_interval: accepts=%0d bad_intervals=%0d required >=3 accepts spaced %0d",
                     acc_q.size(), bad_int, LAT + 2);
        end
        checks++;
        if (bad_ct != 0 || exp_q.size() != 0 || n_out < 3) begin
            failures++;
            $display("FAIL b2b_ct: wrong=%0d outstanding=%0d outputs=%0d required 0/0/>=3",
                     bad_ct, exp_q.size(), n_out);
        end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_pattern_vector();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
